// File: rtl/mluart_rx_fifo.sv
// rtl/mluart_rx_fifo.sv - UART receive byte FIFO, first-word-fall-through, edge-detected write strobe
// Optional overflow flag: define MLUART_RX_FIFO_OVF_EN to add clr_ovf/ovf.
module mluart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK_100MHZ,
    input  logic                  reset_n,
    input  logic                  wr_strobe,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
`ifdef MLUART_RX_FIFO_OVF_EN
    ,
    input  logic                  clr_ovf,
    output logic                  ovf
`endif
);

    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  strobe_prev_q;

    logic push_req;
    logic do_push;
    logic do_pop;
    logic is_full;
    logic is_empty;

    assign is_full  = (count_q == DEPTH_CNT);
    assign is_empty = (count_q == '0);

    // A long strobe is one byte: only its rising edge requests a push.
    assign push_req = wr_strobe & ~strobe_prev_q;
    assign do_pop   = ~is_empty & rd_ready;
    // When full, a push is only accepted if the head leaves on the same edge.
    assign do_push  = push_req & (~is_full | do_pop);

    assign rd_valid = ~is_empty;
    assign full     = is_full;
    assign count    = count_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Control state; previous strobe resets high so a strobe held through reset is ignored.
    always_ff @(posedge CLK_100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            strobe_prev_q <= 1'b1;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            strobe_prev_q <= wr_strobe;
        end
    end

    // Byte storage, deliberately not reset; contents only matter behind valid pointers.
    always_ff @(posedge CLK_100MHZ) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef MLUART_RX_FIFO_OVF_EN
    logic ovf_q;
    logic ovf_d;

    assign ovf = ovf_q;

    // Sticky overflow on a dropped push; a clear on the same edge wins.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end else if (push_req && !do_push) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge CLK_100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_mluart_rx_fifo.sv
// tb/tb_mluart_rx_fifo.sv - self-checking bench for mluart_rx_fifo (queue model plus directed literals)
module tb_mluart_rx_fifo;

    logic       clk;
    logic       reset_n;
    logic       wr_strobe;
    logic [7:0] wr_data;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       full;
    logic [4:0] count;
`ifdef MLUART_RX_FIFO_OVF_EN
    logic       clr_ovf;
    logic       ovf;
`endif

    int errors = 0;
    int checks = 0;
    int maxcnt = 0;
    int got    = 0;

    logic [7:0] mq[$];
    bit         m_prev;
    bit         m_ovf;

    mluart_rx_fifo #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) dut (
        .CLK_100MHZ (clk),
        .reset_n    (reset_n),
        .wr_strobe  (wr_strobe),
        .wr_data    (wr_data),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .full       (full),
        .count      (count)
`ifdef MLUART_RX_FIFO_OVF_EN
        ,
        .clr_ovf    (clr_ovf),
        .ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a byte queue updated by the rules of push-on-rising-strobe and pop-on-ready.
    always @(posedge clk or negedge reset_n) begin
        int sz;
        bit push_req;
        bit pop;
        bit dropped;
        if (!reset_n) begin
            mq.delete();
            m_prev = 1'b1;
            m_ovf  = 1'b0;
        end else begin
            sz       = mq.size();
            push_req = wr_strobe && !m_prev;
            pop      = (sz > 0) && rd_ready;
            dropped  = 1'b0;
            if (pop) void'(mq.pop_front());
            if (push_req) begin
                if (sz < 16 || pop) mq.push_back(wr_data);
                else dropped = 1'b1;
            end
            m_prev = wr_strobe;
`ifdef MLUART_RX_FIFO_OVF_EN
            if (clr_ovf) m_ovf = 1'b0;
            else if (dropped) m_ovf = 1'b1;
`else
            if (dropped) m_ovf = 1'b0;
`endif
        end
    end

    // Every-cycle comparison of DUT outputs against the model, just after the active edge.
    always @(posedge clk) begin
        #2;
        chk("model_count", 32'(count), 32'(mq.size()));
        chk("model_valid", 32'(rd_valid), 32'(mq.size() != 0));
        chk("model_full", 32'(full), 32'(mq.size() == 16));
        if (mq.size() != 0) chk("model_data", 32'(rd_data), 32'(mq[0]));
`ifdef MLUART_RX_FIFO_OVF_EN
        chk("model_ovf", 32'(ovf), 32'(m_ovf));
`endif
        if (int'(count) > maxcnt) maxcnt = int'(count);
    end

    task automatic push_byte(input logic [7:0] d, input int width);
        @(negedge clk);
        wr_data   = d;
        wr_strobe = 1'b1;
        repeat (width) @(negedge clk);
        wr_strobe = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        wr_strobe = 1'b1;
        wr_data   = 8'h3C;
        rd_ready  = 1'b0;
`ifdef MLUART_RX_FIFO_OVF_EN
        clr_ovf   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_count", 32'(count), 0);
        chk("reset_valid", 32'(rd_valid), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("strobe_at_release_count", 32'(count), 0);
        chk("strobe_at_release_valid", 32'(rd_valid), 0);
        wr_strobe = 1'b0;
        @(negedge clk);

        push_byte(8'hA5, 3);
        chk("a5_count", 32'(count), 1);
        chk("a5_data", 32'(rd_data), 32'h A5);
        repeat (3) @(negedge clk);
        chk("a5_single_entry", 32'(count), 1);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk("a5_drained", 32'(count), 0);

        for (int i = 0; i < 16; i++) push_byte(8'(i), 1);
        push_byte(8'hFF, 1);
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);
`ifdef MLUART_RX_FIFO_OVF_EN
        chk("fill_ovf", 32'(ovf), 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(ovf), 0);
`endif
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(rd_data), 32'(i));
            @(negedge clk);
        end
        rd_ready = 1'b0;
        chk("drain_empty", 32'(rd_valid), 0);

        for (int i = 0; i < 16; i++) push_byte(8'(i), 1);
        @(negedge clk);
        wr_data   = 8'h55;
        wr_strobe = 1'b1;
        rd_ready  = 1'b1;
        @(negedge clk);
        wr_strobe = 1'b0;
        rd_ready  = 1'b0;
        chk("fullpp_count", 32'(count), 16);
        chk("fullpp_full", 32'(full), 1);
        rd_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("fullpp_data", 32'(rd_data), 32'(i));
            @(negedge clk);
        end
        chk("fullpp_last", 32'(rd_data), 32'h55);
        @(negedge clk);
        chk("fullpp_empty", 32'(rd_valid), 0);

        maxcnt = 0;
        got    = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rd_valid) begin
                chk("stream_data", 32'(rd_data), 32'(8'h80 + got));
                got++;
            end
            wr_data   = 8'(8'h80 + i);
            wr_strobe = 1'b1;
            @(negedge clk);
            if (rd_valid) begin
                chk("stream_data", 32'(rd_data), 32'(8'h80 + got));
                got++;
            end
            wr_strobe = 1'b0;
        end
        repeat (4) begin
            @(negedge clk);
            if (rd_valid) begin
                chk("stream_data", 32'(rd_data), 32'(8'h80 + got));
                got++;
            end
        end
        chk("stream_total", 32'(got), 40);
        chk("stream_maxcnt", 32'(maxcnt), 1);
        rd_ready = 1'b0;

        for (int i = 0; i < 7; i++) push_byte(8'(8'h20 + i), 1);
        chk("pre_reset_count", 32'(count), 7);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_count", 32'(count), 0);
        chk("async_reset_valid", 32'(rd_valid), 0);
        chk("async_reset_full", 32'(full), 0);
`ifdef MLUART_RX_FIFO_OVF_EN
        chk("async_reset_ovf", 32'(ovf), 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_count", 32'(count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mluart_rx_fifo.md
MLUART_RX_FIFO -- requirements
Module: mluart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 4, giving log2 of the FIFO depth (16 entries).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the byte width.
REQ-003 The block SHALL have port CLK_100MHZ, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 The block SHALL have port wr_strobe, input, 1 bit, the receiver byte-complete indication, possibly several clocks wide.
REQ-006 The block SHALL have port wr_data, input, DATA_WIDTH bits, the received byte, stable while wr_strobe is high.
REQ-007 The block SHALL have port rd_ready, input, 1 bit, consumer accepts the head byte.
REQ-008 The block SHALL have port rd_valid, output, 1 bit, head byte present (equals not empty).
REQ-009 The block SHALL have port rd_data, output, DATA_WIDTH bits, the head byte (first-word-fall-through).
REQ-010 The block SHALL have port full, output, 1 bit, FIFO holds 2^DEPTH_LOG2 bytes.
REQ-011 The block SHALL have port count, output, DEPTH_LOG2+1 bits, number of stored bytes.
REQ-012 The block SHALL have port clr_ovf, input, 1 bit, and port ovf, output, 1 bit (present only per REQ-027).

Function
REQ-013 A push SHALL occur only on the clock where wr_strobe=1 and its registered previous value=0; a strobe held high for any number of clocks SHALL push exactly one byte.
REQ-014 A pushed byte SHALL be written to storage at the push edge; rd_valid and count SHALL reflect it from the next clock.
REQ-015 A pop SHALL occur on a clock edge where rd_valid=1 and rd_ready=1; rd_ready while empty SHALL be ignored.
REQ-016 rd_data SHALL present the oldest stored byte whenever rd_valid=1 and SHALL advance to the next byte the clock after a pop; rd_data when empty is don't-care.
REQ-017 Read and write pointers SHALL be DEPTH_LOG2 bits and wrap from 2^DEPTH_LOG2-1 to 0 without gaps.
REQ-018 Simultaneous push and pop when not full and not empty SHALL both occur, count unchanged.
REQ-019 Simultaneous push and pop when full SHALL both occur: head removed, new byte stored, full stays 1.
REQ-020 Push when empty with rd_ready=1 SHALL store the byte; no pop on that edge.
REQ-021 Push when full without pop SHALL be dropped; storage, pointers and count unchanged.
REQ-022 count SHALL never exceed 2^DEPTH_LOG2 nor underflow below 0.

Reset
REQ-023 On reset_n=0, asynchronously: pointers=0, count=0, rd_valid=0, full=0, ovf=0.
REQ-024 The registered previous-strobe value SHALL reset to 1, so a wr_strobe already high at reset release is not pushed.
REQ-025 Storage contents SHALL not be reset; rd_data is don't-care while empty.
REQ-026 Reset asserted mid-traffic SHALL discard all stored bytes immediately.

Configuration
REQ-027 With macro MLUART_RX_FIFO_OVF_EN defined: ovf SHALL set on any dropped push (REQ-021), stay set until a clock with clr_ovf=1, and clr_ovf SHALL take priority over a simultaneous set.
REQ-028 Without MLUART_RX_FIFO_OVF_EN: ports clr_ovf and ovf SHALL not exist and dropped pushes SHALL be silent; all other behaviour identical.

Verification
REQ-029 Release reset with wr_strobe=1, hold 5 clocks -> count=0, rd_valid=0.
REQ-030 Push 0xA5 with a 3-clock strobe, rd_ready=0 -> count=1 next clock, rd_data=0xA5, exactly one entry.
REQ-031 Push 0x00..0x0F (16 bytes), then a 17th (0xFF) -> full=1, count=16, ovf=1 (if enabled); pop all -> data 0x00..0x0F in order, 0xFF absent.
REQ-032 While full, push 0x55 on the same clock as a pop -> count=16, full=1, 0x55 read last after 0x01..0x0F.
REQ-033 Push and pop 40 bytes continuously with rd_ready=1 -> pointers wrap twice, all 40 bytes read in order, count never above 1.
REQ-034 Assert reset_n=0 with count=7 -> count=0, rd_valid=0, full=0, ovf=0 immediately without a clock edge.
